// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage multiply/divide request and HI/LO result bundle.
// master drives op/start/operands/cancel; slave returns busy and HI/LO.
interface e_mdu_if;
  logic [3:0]  E_MDUOp;
  logic        E_Start;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_Req;
  logic        E_Busy;
  logic [31:0] E_RDHI;
  logic [31:0] E_RDLO;

  modport master (
    output E_MDUOp, E_Start, E_A, E_B, E_Req,
    input  E_Busy, E_RDHI, E_RDLO
  );

  modport slave (
    input  E_MDUOp, E_Start, E_A, E_B, E_Req,
    output E_Busy, E_RDHI, E_RDLO
  );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle mult/div unit holding HI/LO, fixed latency.
// Ports: clk, reset (sync, active-low), bus (e_mdu_if.slave).
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave bus
);
  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo, r_tmp_hi, r_tmp_lo;
  logic          r_commit;

  logic w_mul, w_mul_s, w_div, w_div_s;
  logic w_mthi, w_mtlo;

  always_comb begin
    w_mul   = 1'b0;
    w_mul_s = 1'b0;
    w_div   = 1'b0;
    w_div_s = 1'b0;
    w_mthi  = 1'b0;
    w_mtlo  = 1'b0;
    unique case (1'b1)
      bus.E_MDUOp == 4'd1: begin
        w_mul   = 1'b1;
        w_mul_s = 1'b1;
      end
      bus.E_MDUOp == 4'd2: w_mul = 1'b1;
      bus.E_MDUOp == 4'd3: begin
        w_div   = 1'b1;
        w_div_s = 1'b1;
      end
      bus.E_MDUOp == 4'd4: w_div = 1'b1;
      bus.E_MDUOp == 4'd5: w_mthi = 1'b1;
      bus.E_MDUOp == 4'd6: w_mtlo = 1'b1;
      default: ;
    endcase
  end

  logic w_idle, w_start, w_wr_hi, w_wr_lo;
  assign w_idle  = (r_state == S_IDLE);
  assign w_start = w_idle & bus.E_Start
                 & (w_mul | w_div) & ~bus.E_Req;
  assign w_wr_hi = w_idle & w_mthi & ~bus.E_Req;
  assign w_wr_lo = w_idle & w_mtlo & ~bus.E_Req;

  logic [63:0] w_ma, w_mb, w_prod;
  assign w_ma = {{32{w_mul_s & bus.E_A[31]}}, bus.E_A};
  assign w_mb = {{32{w_mul_s & bus.E_B[31]}}, bus.E_B};
  // Low 64 bits of the extended product are exact for both signednesses.
  assign w_prod = w_ma * w_mb;

  // Signed divide via magnitudes: avoids INT_MIN/-1 overflow and
  // gives truncation toward zero with remainder sign of the dividend.
  logic        w_an, w_bn, w_bz;
  logic [31:0] w_am, w_bm, w_bs, w_q, w_r, w_quo, w_rem;
  assign w_an  = w_div_s & bus.E_A[31];
  assign w_bn  = w_div_s & bus.E_B[31];
  assign w_bz  = (bus.E_B == 32'd0);
  assign w_am  = w_an ? -bus.E_A : bus.E_A;
  assign w_bm  = w_bn ? -bus.E_B : bus.E_B;
  assign w_bs  = w_bz ? 32'd1 : w_bm;
  assign w_q   = w_am / w_bs;
  assign w_r   = w_am % w_bs;
  assign w_quo = (w_an ^ w_bn) ? -w_q : w_q;
  assign w_rem = w_an ? -w_r : w_r;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next = S_BUSY;
      S_BUSY: if (r_cnt == CW'(1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
      r_cnt    <= '0;
      r_commit <= 1'b0;
    end else if (w_idle) begin
      if (w_start) begin
        r_tmp_hi <= w_mul ? w_prod[63:32] : w_rem;
        r_tmp_lo <= w_mul ? w_prod[31:0]  : w_quo;
        r_cnt    <= w_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        // Divide by zero still spends the full latency but never commits.
        r_commit <= ~(w_div & w_bz);
      end
      if (w_wr_hi) r_hi <= bus.E_A;
      if (w_wr_lo) r_lo <= bus.E_A;
    end else begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1) && r_commit) begin
        r_hi <= r_tmp_hi;
        r_lo <= r_tmp_lo;
      end
    end
  end

  assign bus.E_Busy = (r_state == S_BUSY);
  assign bus.E_RDHI = r_hi;
  assign bus.E_RDLO = r_lo;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed table of MDU ops plus reset/interlock sequences.
// Checks busy length, HI/LO hold while busy, and final HI/LO.
module tb_e_mdu;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        start;
    logic        req;
    logic        noise;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.E_MDUOp = 4'd0;
    bus.E_Start = 1'b0;
    bus.E_A     = 32'd0;
    bus.E_B     = 32'd0;
    bus.E_Req   = 1'b0;
  endtask

  // Traffic that must be ignored while the unit is busy.
  task automatic noise(input int n);
    idle();
    case (n)
      1: begin
        bus.E_MDUOp = 4'd5;
        bus.E_A     = 32'h5555;
      end
      2: begin
        bus.E_MDUOp = 4'd3;
        bus.E_Start = 1'b1;
        bus.E_A     = 32'd100;
        bus.E_B     = 32'd1;
      end
      3: begin
        bus.E_MDUOp = 4'd6;
        bus.E_A     = 32'h6666;
        bus.E_Req   = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    @(negedge clk);
    bus.E_MDUOp = v.op;
    bus.E_Start = v.start;
    bus.E_A     = v.a;
    bus.E_B     = v.b;
    bus.E_Req   = v.req;
    @(posedge clk);
    #1;
    idle();
    n = 0;
    while (bus.E_Busy && n < 100) begin
      n++;
      chk($sformatf("v%0d hold_hi", idx), bus.E_RDHI, m_hi);
      chk($sformatf("v%0d hold_lo", idx), bus.E_RDLO, m_lo);
      if (v.noise) noise(n);
      @(posedge clk);
      #1;
    end
    idle();
    chk($sformatf("v%0d busy_len", idx), 32'(n), 32'(v.cyc));
    chk($sformatf("v%0d hi", idx), bus.E_RDHI, v.hi);
    chk($sformatf("v%0d lo", idx), bus.E_RDLO, v.lo);
    m_hi = v.hi;
    m_lo = v.lo;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{4'd1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,
               5, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[1]  = '{4'd2, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,
               5, 32'h1, 32'hFFFFFFFE};
    vt[2]  = '{4'd4, 1'b1, 1'b0, 1'b0, 32'd7, 32'd2,
               10, 32'd1, 32'd3};
    vt[3]  = '{4'd3, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,
               10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[4]  = '{4'd3, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF,
               10, 32'h0, 32'h80000000};
    vt[5]  = '{4'd3, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0,
               10, 32'h0, 32'h80000000};
    vt[6]  = '{4'd1, 1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF,
               5, 32'h3FFFFFFF, 32'h00000001};
    vt[7]  = '{4'd4, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0,
               10, 32'h3FFFFFFF, 32'h00000001};
    vt[8]  = '{4'd3, 1'b1, 1'b0, 1'b0, 32'd7, 32'hFFFFFFFE,
               10, 32'd1, 32'hFFFFFFFD};
    vt[9]  = '{4'd6, 1'b0, 1'b0, 1'b0, 32'h1234, 32'd0,
               0, 32'd1, 32'h1234};
    vt[10] = '{4'd5, 1'b0, 1'b0, 1'b0, 32'hABCD, 32'd0,
               0, 32'hABCD, 32'h1234};
    vt[11] = '{4'd1, 1'b1, 1'b1, 1'b0, 32'd3, 32'd4,
               0, 32'hABCD, 32'h1234};
    vt[12] = '{4'd7, 1'b1, 1'b0, 1'b0, 32'd3, 32'd4,
               0, 32'hABCD, 32'h1234};
    vt[13] = '{4'd5, 1'b0, 1'b1, 1'b0, 32'hFFFF, 32'd0,
               0, 32'hABCD, 32'h1234};
    vt[14] = '{4'd2, 1'b1, 1'b0, 1'b0, 32'h10000, 32'h10000,
               5, 32'd1, 32'd0};
    vt[15] = '{4'd1, 1'b1, 1'b0, 1'b1, 32'd3, 32'd4,
               5, 32'd0, 32'd12};
    vt[16] = '{4'd1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFD, 32'd4,
               5, 32'hFFFFFFFF, 32'hFFFFFFF4};

    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(bus.E_Busy), 32'd0);
    chk("rst hi", bus.E_RDHI, 32'd0);
    chk("rst lo", bus.E_RDLO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(i, vt[i]);

    // Reset in the middle of a divide: no commit afterwards.
    @(negedge clk);
    bus.E_MDUOp = 4'd3;
    bus.E_Start = 1'b1;
    bus.E_A     = 32'd100;
    bus.E_B     = 32'd7;
    @(posedge clk);
    #1;
    idle();
    chk("mid busy", 32'(bus.E_Busy), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst busy", 32'(bus.E_Busy), 32'd0);
    chk("midrst hi", bus.E_RDHI, 32'd0);
    chk("midrst lo", bus.E_RDLO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post busy", 32'(bus.E_Busy), 32'd0);
    chk("post hi", bus.E_RDHI, 32'd0);
    chk("post lo", bus.E_RDLO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    run_vec(99, '{4'd1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5,
                  5, 32'd0, 32'd15});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu/mthi/mtlo and holds the architectural HI/LO registers.
- Models the fixed MIPS latency: Busy drives the stall logic for mfhi/mflo/md instructions.
- E_RDHI/E_RDLO feed the E-stage HI/LO select mux directly, which produces E_MDData.

Parameters:
- MULT_CYCLES, 5, cycles from mult/multu start to HI/LO commit (>=1).
- DIV_CYCLES, 10, cycles from div/divu start to HI/LO commit (>=1).

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- E_MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others treated as none.
- E_Start  input  1  start strobe, valid with E_MDUOp 1..4 for one cycle.
- E_A  input  32  rs operand (forwarded); dividend or multiplicand; mthi/mtlo source.
- E_B  input  32  rt operand (forwarded); divisor or multiplier.
- E_Req  input  1  exception/interrupt cancel; suppresses the E-stage operation this cycle.
- E_Busy  output  1  operation in progress.
- E_RDHI  output  32  current HI register.
- E_RDLO  output  32  current LO register.

Behaviour:
- Reset (reset==0 at posedge): HI=0, LO=0, temp regs=0, counter=0, state IDLE, E_Busy=0. Reset has priority over everything and aborts any in-flight op with no commit.
- States:
  - IDLE: E_Busy=0.
  - BUSY: E_Busy=1, counter>0.
- IDLE -> BUSY on a posedge with E_Start=1, E_MDUOp in 1..4 and E_Req=0.
  - Operands are captured and the result is computed into tmpHI/tmpLO.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
- In BUSY, the counter decrements each posedge. At the edge where counter==1: HI=tmpHI, LO=tmpLO, counter=0, return to IDLE.
- Timing: a start captured at edge T gives E_Busy high for exactly N cycles (edges T+1..T+N). New HI/LO are visible after edge T+N, in the same cycle E_Busy falls.
- HI/LO outputs keep their old values throughout BUSY. There is no early update.
- mult: signed 32x32 -> 64; HI=upper 32 bits, LO=lower 32 bits.
- multu: unsigned 32x32 -> 64; HI=upper 32 bits, LO=lower 32 bits.
- div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu: unsigned; LO=quotient, HI=remainder.
- Divide by zero (div/divu with E_B==0): full DIV_CYCLES busy period, then HI/LO left unchanged (no commit).
- mthi/mtlo in IDLE with E_Req=0: HI (or LO) = E_A at the next edge. Zero latency, no busy.
- Ignored inputs:
  - mthi/mtlo in BUSY: ignored; the hazard unit guarantees a stall, and the RTL must still not write.
  - E_Start in BUSY: ignored; no restart, no counter reload.
  - E_Start with E_MDUOp not in 1..4: ignored.
- E_Req=1 suppresses start and mthi/mtlo in that cycle. It does not abort an op already in BUSY, which commits normally.
- E_Busy is a registered state bit only. Any "start pending" combination for the stall unit is built outside this block.

Test Plan:
- Reset then mult:
  - Stimulus: reset low 2 cycles, then mult with A=0xFFFFFFFF, B=2.
  - Response: E_Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; before commit HI=LO=0.
- multu then divu:
  - Stimulus: multu A=0xFFFFFFFF, B=2.
  - Response: HI=1, LO=0xFFFFFFFE.
  - Stimulus: then divu A=7, B=2.
  - Response: 10 busy cycles, then LO=3, HI=1.
- Signed div corners:
  - div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
  - div A=5, B=0 -> busy 10 cycles, HI/LO unchanged.
- mthi/mtlo and busy interlock:
  - Stimulus: mtlo A=0x1234 in IDLE.
  - Response: LO=0x1234 next cycle, E_Busy stays 0.
  - Stimulus: start mult, then issue mthi and a second E_Start during BUSY.
  - Response: both ignored; only the mult result commits, after exactly 5 cycles.
- E_Req suppression:
  - Stimulus: E_Start mult with E_Req=1.
  - Response: E_Busy stays 0, HI/LO unchanged.
  - Stimulus: E_Req=1 raised while BUSY.
  - Response: op still commits at the normal time.
- Reset mid-operation:
  - Stimulus: reset low at busy cycle 3 of a div.
  - Response: next edge E_Busy=0, HI=LO=0, no later commit; a new mult immediately after works normally.
